// File: rtl/jstk_spi_responder.sv
// PmodJSTK joystick emulator: SPI mode-0 slave, oversampled in the system clock domain.
// Answers the 5-byte frame with X/Y/buttons and captures the master's LED command byte.
module jstk_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] leds,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [1:0] StArmedWait = 2'd0;
  localparam logic [1:0] StIdle      = 2'd1;
  localparam logic [1:0] StActive    = 2'd2;

  localparam int unsigned CntW = 6;
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   ss_prev_q, sclk_prev_q;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic [1:0]            leds_q, leds_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [FRAME_BITS-1:0] snap;
  logic                  unused_bits;

  // Synchronizers keep sampling through reset so the post-reset state sees the true SS level.
  always_ff @(posedge clk) begin
    ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_prev_q   <= ss_s;
    sclk_prev_q <= sclk_s;
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  assign snap = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    leds_d    = leds_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // Byte 0 is the first byte received, so it sits at the top of rx once the frame is complete.
    if (done_q && rx_q[FRAME_BITS-1]) begin
      leds_d = rx_q[FRAME_BITS-7:FRAME_BITS-8];
    end

    case (state_q)
      StArmedWait: begin
        if (ss_rise) state_d = StIdle;
      end
      StIdle: begin
        if (ss_fall) begin
          tx_d      = snap;
          bit_cnt_d = '0;
          miso_d    = snap[FRAME_BITS-1];
          oe_d      = 1'b1;
          state_d   = StActive;
        end
      end
      StActive: begin
        if (ss_rise) begin
          miso_d  = 1'b0;
          oe_d    = 1'b0;
          state_d = StIdle;
          done_d  = (bit_cnt_q == CntFull);
          err_d   = (bit_cnt_q != CntFull);
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt_q != CntSat) bit_cnt_d = bit_cnt_q + CntW'(1);
          end
          // Zeros shift in behind the frame, so overrun bits read back as 0.
          if (sclk_fall) begin
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            miso_d = tx_q[FRAME_BITS-2];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ss_s ? StIdle : StArmedWait;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      leds_q    <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      leds_q    <= leds_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign unused_bits = ^{rx_q, tx_q};

  assign miso       = miso_q;
  assign miso_oe    = oe_q;
  assign leds       = leds_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: bit-banged SPI master with hand-computed frames.
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi;
  logic       miso, miso_oe;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [1:0] leds;
  logic       frame_done, frame_err;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [47:0] rd;
  logic        oe_first;
  logic        oe_after_rst;

  always #5 clk = ~clk;

  jstk_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .leds       (leds),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  // Counting asserted cycles also catches pulses wider than one clock.
  always @(posedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode-0 master: 6-clk half periods; bits taken MSB first from tx[47:...].
  task automatic xfer(input int nbits, input logic [47:0] tx, input int chg_bit,
                      input int rst_bit);
    rd           = '0;
    oe_after_rst = 1'b0;
    ss           = 1'b0;
    tick(8);
    oe_first = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = 10'h3FF;
      if (i == rst_bit) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
      end
      mosi = tx[47-i];
      tick(6);
      rd = {rd[46:0], miso};
      if (rst_bit >= 0 && i >= rst_bit) oe_after_rst = oe_after_rst | miso_oe;
      sclk = 1'b1;
      tick(6);
      sclk = 1'b0;
    end
    tick(6);
    ss   = 1'b1;
    mosi = 1'b0;
    tick(8);
  endtask

  initial begin
    rst     = 1'b1;
    ss      = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    x_pos   = 10'h2A5;
    y_pos   = 10'h0FF;
    buttons = 3'b101;
    tick(5);
    rst = 1'b0;
    tick(1);
    chk("rst_miso", miso, 1'b0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_leds", leds, 2'b00);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", frame_err, 1'b0);

    // 1: basic frame, no LED command
    xfer(40, 48'h00_0000_0000_00, -1, -1);
    chk("t1_frame", rd[39:0], 40'hA5_02_FF_00_05);
    chk("t1_oe_active", oe_first, 1'b1);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_leds", leds, 2'b00);
    chk("t1_idle_oe", miso_oe, 1'b0);

    // 2: LED command accepted, then a byte0 without bit7 is ignored
    xfer(40, 48'h83_0000_0000_00, -1, -1);
    chk("t2_leds_set", leds, 2'b11);
    chk("t2_done", done_cnt, 2);
    xfer(40, 48'h01_0000_0000_00, -1, -1);
    chk("t2_leds_hold", leds, 2'b11);
    chk("t2_frame", rd[39:0], 40'hA5_02_FF_00_05);

    // 3: snapshot taken at SS fall
    x_pos = 10'h000;
    xfer(40, 48'h0, 5, -1);
    chk("t3_snap_old", rd[39:0], 40'h00_00_FF_00_05);
    xfer(40, 48'h0, -1, -1);
    chk("t3_snap_new", rd[39:0], 40'hFF_03_FF_00_05);
    chk("t3_done", done_cnt, 5);

    // 4: short frame
    xfer(17, 48'h83_0000_0000_00, -1, -1);
    chk("t4_bits", rd[16:0], 17'h1FE07);
    chk("t4_err", err_cnt, 1);
    chk("t4_no_done", done_cnt, 5);
    chk("t4_leds", leds, 2'b11);
    xfer(40, 48'h0, -1, -1);
    chk("t4_recover", rd[39:0], 40'hFF_03_FF_00_05);
    chk("t4_recover_done", done_cnt, 6);

    // 5: reset mid-frame with SS low; must sit out the rest of the frame
    xfer(40, 48'h83_0000_0000_00, -1, 20);
    chk("t5_oe_quiet", oe_after_rst, 1'b0);
    chk("t5_leds_rst", leds, 2'b00);
    chk("t5_no_done", done_cnt, 6);
    chk("t5_no_err", err_cnt, 1);
    chk("t5_idle_oe", miso_oe, 1'b0);
    chk("t5_idle_miso", miso, 1'b0);
    xfer(40, 48'h0, -1, -1);
    chk("t5_rejoin", rd[39:0], 40'hFF_03_FF_00_05);
    chk("t5_rejoin_oe", oe_first, 1'b1);
    chk("t5_rejoin_done", done_cnt, 7);

    // 6: overrun
    xfer(42, 48'h0, -1, -1);
    chk("t6_bits", rd[41:0], {40'hFF_03_FF_00_05, 2'b00});
    chk("t6_err", err_cnt, 2);
    chk("t6_no_done", done_cnt, 7);
    chk("t6_idle_oe", miso_oe, 1'b0);
    chk("t6_idle_miso", miso, 1'b0);
    chk("t6_leds", leds, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
